// File: rtl/arp_request_gen_if.sv
// Request/response handshake plus AXI-Stream TX and RX taps of the ARP request generator.
// master = generator side, slave = the attached client/MAC side.
interface arp_request_gen_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic                req_valid;
    logic [31:0]         req_ip;
    logic                req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_ip;
    logic [47:0]         resp_mac;
    logic                resp_fail;

    logic [DATA_W-1:0]   m_axis_tdata;
    logic [DATA_W/8-1:0] m_axis_tstrb;
    logic [USER_W-1:0]   m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;

    logic [DATA_W-1:0]   s_axis_tdata;
    logic [DATA_W/8-1:0] s_axis_tstrb;
    logic [USER_W-1:0]   s_axis_tuser;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tlast;

    modport master (
        input  req_valid, req_ip, resp_ready,
        output req_ready, resp_valid, resp_ip, resp_mac, resp_fail,
        output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready
    );

    modport slave (
        output req_valid, req_ip, resp_ready,
        input  req_ready, resp_valid, resp_ip, resp_mac, resp_fail,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready
    );
endinterface

// File: rtl/arp_request_gen.sv
// Broadcasts a 2-beat ARP request for req_ip, retries on timeout, reports MAC or failure.
// Request->tvalid and reply->resp_valid are 1 cycle; TX holds on tready=0, RX tap never stalls.
module arp_request_gen #(
    parameter int         C_M_AXIS_DATA_WIDTH  = 256,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter int         DST_PORT_POS         = 24,
    parameter logic [7:0] TX_DST_PORTS         = 8'h55,
    parameter int         TIMEOUT_CYCLES       = 1000000,
    parameter int         MAX_RETRIES          = 3
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic [47:0]       my_mac,
    input  logic [31:0]       my_ip,
    arp_request_gen_if.master bus
);
    localparam int          STRB_W    = C_M_AXIS_DATA_WIDTH / 8;
    localparam int          TIMER_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int          RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [15:0] FRAME_LEN = 16'd60;

    // Fields are stored in wire byte order: byte 0 of the frame sits in bits [7:0].
    typedef struct packed {
        logic [31:0] spa;
        logic [47:0] sha;
        logic [15:0] op;
        logic [7:0]  plen;
        logic [7:0]  hlen;
        logic [15:0] ptype;
        logic [15:0] htype;
        logic [15:0] etype;
        logic [47:0] src;
        logic [47:0] dst;
    } hdr_t;

    typedef struct packed {
        logic [175:0] pad;
        logic [31:0]  tpa;
        logic [47:0]  tha;
    } tail_t;

    typedef enum logic [2:0] {IDLE, TX_HDR, TX_TAIL, WAIT, RESP} state_t;

    function automatic logic [47:0] swap48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = v[8*(5-i) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(3-i) +: 8];
        return r;
    endfunction

    state_t                          state, state_n;
    logic [31:0]                     ip_q;
    logic [31:0]                     sip_q;
    logic [47:0]                     mac_q;
    logic [TIMER_W-1:0]              timer;
    logic [RETRY_W-1:0]              retry;
    logic                            rx_first;
    logic [47:0]                     resp_mac_q;
    logic                            resp_fail_q;

    logic                            take_req;
    logic                            start_wait;
    logic                            retry_now;
    logic                            match_hit;
    logic                            fail_now;
    logic                            rx_match;
    logic                            timeout;

    hdr_t                            hdr;
    tail_t                           tail;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] user_dat;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  tx_dat;
    logic [STRB_W-1:0]               tx_strb;
    logic                            tx_vld;
    logic                            tx_last;
    logic                            req_rdy;
    logic                            resp_vld;
    logic                            unused_rx;

    // Beat images depend only on registers latched at request time, so they stay
    // stable for as long as the sink stalls.
    always_comb begin
        hdr       = '0;
        hdr.dst   = '1;
        hdr.src   = swap48(mac_q);
        hdr.etype = 16'h0608;
        hdr.htype = 16'h0100;
        hdr.ptype = 16'h0008;
        hdr.hlen  = 8'h06;
        hdr.plen  = 8'h04;
        hdr.op    = 16'h0100;
        hdr.sha   = swap48(mac_q);
        hdr.spa   = swap32(sip_q);

        tail      = '0;
        tail.tpa  = swap32(ip_q);

        user_dat                       = '0;
        user_dat[15:0]                 = FRAME_LEN;
        user_dat[DST_PORT_POS +: 8]    = TX_DST_PORTS;
    end

    assign rx_match = (state == WAIT) && bus.s_axis_tvalid && rx_first
                   && (bus.s_axis_tdata[111:96]  == 16'h0608)
                   && (bus.s_axis_tdata[175:160] == 16'h0200)
                   && (bus.s_axis_tdata[255:224] == swap32(ip_q));

    assign timeout = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) state <= IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n    = state;
        take_req   = 1'b0;
        start_wait = 1'b0;
        retry_now  = 1'b0;
        match_hit  = 1'b0;
        fail_now   = 1'b0;
        tx_vld     = 1'b0;
        tx_last    = 1'b0;
        tx_strb    = '0;
        tx_dat     = '0;
        req_rdy    = 1'b0;
        resp_vld   = 1'b0;

        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) begin
                    take_req = 1'b1;
                    state_n  = TX_HDR;
                end
            end
            TX_HDR: begin
                tx_vld  = 1'b1;
                tx_strb = '1;
                tx_dat  = hdr;
                if (bus.m_axis_tready) state_n = TX_TAIL;
            end
            TX_TAIL: begin
                tx_vld  = 1'b1;
                tx_last = 1'b1;
                tx_strb = STRB_W'(32'h0FFF_FFFF);
                tx_dat  = tail;
                if (bus.m_axis_tready) begin
                    start_wait = 1'b1;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                // A reply landing on the expiry cycle still counts as success.
                if (rx_match) begin
                    match_hit = 1'b1;
                    state_n   = RESP;
                end else if (timeout) begin
                    if (retry < RETRY_W'(MAX_RETRIES)) begin
                        retry_now = 1'b1;
                        state_n   = TX_HDR;
                    end else begin
                        fail_now = 1'b1;
                        state_n  = RESP;
                    end
                end
            end
            RESP: begin
                resp_vld = 1'b1;
                if (bus.resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            ip_q        <= '0;
            sip_q       <= '0;
            mac_q       <= '0;
            timer       <= '0;
            retry       <= '0;
            rx_first    <= 1'b1;
            resp_mac_q  <= '0;
            resp_fail_q <= 1'b0;
        end else begin
            if (take_req) begin
                ip_q  <= bus.req_ip;
                mac_q <= my_mac;
                sip_q <= my_ip;
                retry <= '0;
            end
            if (retry_now) retry <= retry + 1'b1;

            if (start_wait)                     timer <= '0;
            else if (state == WAIT && !timeout) timer <= timer + 1'b1;

            // Passive tap: frame boundaries are tracked even when no request is pending.
            if (bus.s_axis_tvalid) rx_first <= bus.s_axis_tlast;

            if (match_hit) begin
                resp_mac_q  <= swap48(bus.s_axis_tdata[223:176]);
                resp_fail_q <= 1'b0;
            end
            if (fail_now) begin
                resp_mac_q  <= '0;
                resp_fail_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready     = req_rdy;
    assign bus.resp_valid    = resp_vld;
    assign bus.resp_ip       = ip_q;
    assign bus.resp_mac      = resp_mac_q;
    assign bus.resp_fail     = resp_fail_q;

    assign bus.m_axis_tdata  = tx_dat;
    assign bus.m_axis_tstrb  = tx_strb;
    assign bus.m_axis_tuser  = tx_vld ? user_dat : '0;
    assign bus.m_axis_tvalid = tx_vld;
    assign bus.m_axis_tlast  = tx_last;
    assign bus.s_axis_tready = 1'b1;

    assign unused_rx = ^{bus.s_axis_tstrb, bus.s_axis_tuser,
                         bus.s_axis_tdata[95:0], bus.s_axis_tdata[159:112]};
endmodule

// File: tb/tb_arp_request_gen.sv
// Directed/randomised bench for arp_request_gen; expected frames come from an ARP byte-layout model.
module tb_arp_request_gen;
    localparam int TO = 16;
    localparam int MR = 2;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic [47:0] my_mac;
    logic [31:0] my_ip;

    arp_request_gen_if #(.DATA_W(256), .USER_W(128)) bus ();

    arp_request_gen #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .axi_aclk  (axi_aclk),
        .axi_reset (axi_reset),
        .my_mac    (my_mac),
        .my_ip     (my_ip),
        .bus       (bus)
    );

    always #5 axi_aclk = ~axi_aclk;

    int    checks = 0;
    int    errors = 0;
    beat_t txq[$];
    beat_t held;
    bit    holding = 1'b0;
    int    stall_viol = 0;

    // Sink-side monitor: records accepted beats and flags any change while stalled.
    always @(negedge axi_aclk) begin
        beat_t cur;
        cur.d = bus.m_axis_tdata;
        cur.s = bus.m_axis_tstrb;
        cur.u = bus.m_axis_tuser;
        cur.l = bus.m_axis_tlast;
        if (axi_reset) holding = 1'b0;
        else if (bus.m_axis_tvalid) begin
            if (holding && cur !== held) stall_viol++;
            if (bus.m_axis_tready) begin
                txq.push_back(cur);
                holding = 1'b0;
            end else begin
                held    = cur;
                holding = 1'b1;
            end
        end else if (holding) begin
            stall_viol++;
            holding = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    // Byte n of the 60-byte ARP request frame, straight from the Ethernet/ARP layout.
    function automatic logic [7:0] frame_byte(input int n, input logic [47:0] mac,
                                              input logic [31:0] sip, input logic [31:0] tip);
        if (n < 6)  return 8'hFF;
        if (n < 12) return mac[8*(11-n) +: 8];
        if (n < 22) begin
            case (n)
                12: return 8'h08;
                13: return 8'h06;
                15: return 8'h01;
                16: return 8'h08;
                18: return 8'h06;
                19: return 8'h04;
                21: return 8'h01;
                default: return 8'h00;
            endcase
        end
        if (n < 28) return mac[8*(27-n) +: 8];
        if (n < 32) return sip[8*(31-n) +: 8];
        if (n < 38) return 8'h00;
        if (n < 42) return tip[8*(41-n) +: 8];
        return 8'h00;
    endfunction

    function automatic beat_t exp_beat(input int k, input logic [47:0] mac,
                                       input logic [31:0] sip, input logic [31:0] tip);
        beat_t b;
        b = '0;
        for (int j = 0; j < 32; j++) begin
            b.d[8*j +: 8] = frame_byte(32*k + j, mac, sip, tip);
            b.s[j]        = (32*k + j) < 60;
        end
        b.u[15:0]  = 16'd60;
        b.u[24 +: 8] = 8'h55;
        b.l        = (k == 1);
        return b;
    endfunction

    function automatic logic [255:0] reply_data(input logic [15:0] etype, input logic [15:0] op,
                                                input logic [47:0] smac, input logic [31:0] sip);
        logic [255:0] d;
        d = '0;
        d[8*12 +: 8] = etype[15:8];
        d[8*13 +: 8] = etype[7:0];
        d[8*20 +: 8] = op[15:8];
        d[8*21 +: 8] = op[7:0];
        for (int j = 0; j < 6; j++) d[8*(22+j) +: 8] = smac[8*(5-j) +: 8];
        for (int j = 0; j < 4; j++) d[8*(28+j) +: 8] = sip[8*(3-j) +: 8];
        return d;
    endfunction

    task automatic check_frames(input string tag, input int nframes, input logic [47:0] mac,
                                input logic [31:0] sip, input logic [31:0] tip);
        check({tag, "_beats"}, txq.size(), 2*nframes);
        for (int i = 0; i < txq.size() && i < 2*nframes; i++)
            check($sformatf("%s_beat%0d", tag, i), txq[i], exp_beat(i % 2, mac, sip, tip));
    endtask

    task automatic issue_req(input logic [31:0] ip);
        bus.req_valid = 1'b1;
        bus.req_ip    = ip;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // phase < 0: sink always ready; otherwise ready on one cycle in three.
    task automatic wait_beats(input int n, input int phase);
        int c = 0;
        while (txq.size() < n && c < 300) begin
            bus.m_axis_tready = (phase < 0) ? 1'b1 : ((c % 3) == phase);
            tick();
            c++;
        end
        bus.m_axis_tready = 1'b1;
    endtask

    task automatic rx_beat(input logic [255:0] d, input logic last);
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tstrb  = '1;
        bus.s_axis_tvalid = 1'b1;
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
    endtask

    task automatic ack_resp();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [47:0] smac;
        logic [31:0] ip;
        logic [31:0] prev_ip;
        int          c;
        bit          seen;

        axi_reset         = 1'b1;
        my_mac            = '0;
        my_ip             = '0;
        bus.req_valid     = 1'b0;
        bus.req_ip        = '0;
        bus.resp_ready    = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tstrb  = '0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) tick();

        check("rst_req_ready",  bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_fail",  bus.resp_fail, 1'b0);
        check("rst_resp_mac",   bus.resp_mac, 48'h0);
        check("rst_resp_ip",    bus.resp_ip, 32'h0);
        check("rst_tvalid",     bus.m_axis_tvalid, 1'b0);
        check("rst_tlast",      bus.m_axis_tlast, 1'b0);
        check("rst_s_tready",   bus.s_axis_tready, 1'b1);
        axi_reset = 1'b0;
        tick();

        // Reference transaction 10.0.0.1 -> 10.0.0.2, reply from 02:00:00:00:00:02.
        my_mac = 48'h02_00_00_00_00_01;
        my_ip  = 32'h0A00_0001;
        txq.delete();
        issue_req(32'h0A00_0002);
        check("lat_first_tvalid", bus.m_axis_tvalid, 1'b1);
        check("tx_req_ready_busy", bus.req_ready, 1'b0);
        wait_beats(2, -1);
        check_frames("ref", 1, my_mac, my_ip, 32'h0A00_0002);
        if (txq.size() >= 2) begin
            check("ref_spa_field",   txq[0].d[255:224], 32'h0100_000A);
            check("ref_etype_field", txq[0].d[111:96], 16'h0608);
            check("ref_tpa_field",   txq[1].d[79:48], 32'h0200_000A);
        end
        check("ref_wait_no_resp", bus.resp_valid, 1'b0);
        rx_beat(reply_data(16'h0806, 16'h0002, 48'h02_00_00_00_00_02, 32'h0A00_0002), 1'b0);
        check("ref_resp_valid", bus.resp_valid, 1'b1);
        check("ref_resp_mac",   bus.resp_mac, 48'h02_00_00_00_00_02);
        check("ref_resp_fail",  bus.resp_fail, 1'b0);
        check("ref_resp_ip",    bus.resp_ip, 32'h0A00_0002);
        rx_beat('0, 1'b1);
        check("ref_resp_hold",  bus.resp_mac, 48'h02_00_00_00_00_02);
        ack_resp();
        check("ref_idle_again", {bus.resp_valid, bus.req_ready}, 2'b01);

        // No reply: MR+1 identical frames, each followed by TO waiting cycles, then failure.
        my_mac = {16'($urandom), 32'($urandom)};
        my_ip  = $urandom;
        ip     = $urandom;
        txq.delete();
        issue_req(ip);
        c = 0;
        while (bus.resp_valid !== 1'b1 && c < 400) begin
            tick();
            c++;
        end
        check("to_resp_valid", bus.resp_valid, 1'b1);
        check("to_latency", c, (MR + 1) * (TO + 2));
        check("to_resp_fail", bus.resp_fail, 1'b1);
        check("to_resp_mac", bus.resp_mac, 48'h0);
        check("to_resp_ip", bus.resp_ip, ip);
        check_frames("to", MR + 1, my_mac, my_ip, ip);
        ack_resp();

        // Randomised transactions with a sink ready one cycle in three.
        for (int t = 0; t < 3; t++) begin
            my_mac = {16'($urandom), 32'($urandom)};
            my_ip  = $urandom;
            ip     = $urandom;
            smac   = {16'($urandom), 32'($urandom)};
            txq.delete();
            stall_viol = 0;
            issue_req(ip);
            my_mac = ~my_mac;
            my_ip  = ~my_ip;
            wait_beats(2, $urandom_range(2, 0));
            check_frames($sformatf("stall%0d", t), 1, ~my_mac, ~my_ip, ip);
            check($sformatf("stall%0d_stable", t), stall_viol, 0);
            repeat ($urandom_range(5, 0)) tick();
            rx_beat(reply_data(16'h0806, 16'h0002, smac, ip), 1'b1);
            check($sformatf("stall%0d_resp", t), {bus.resp_valid, bus.resp_fail, bus.resp_mac},
                  {1'b1, 1'b0, smac});
            ack_resp();
            prev_ip = ip;
        end

        // A valid-looking reply while idle is ignored.
        rx_beat(reply_data(16'h0806, 16'h0002, 48'h11_22_33_44_55_66, prev_ip), 1'b1);
        check("idle_reply_ignored", {bus.resp_valid, bus.req_ready}, 2'b01);

        // Distractor replies, then the genuine reply on the expiry cycle.
        my_mac = {16'($urandom), 32'($urandom)};
        my_ip  = $urandom;
        ip     = $urandom;
        smac   = {16'($urandom), 32'($urandom)};
        txq.delete();
        issue_req(ip);
        wait_beats(2, -1);
        rx_beat(reply_data(16'h0806, 16'h0002, smac, ip ^ 32'h1), 1'b1);
        rx_beat(reply_data(16'h0806, 16'h0001, smac, ip), 1'b1);
        rx_beat(reply_data(16'h0800, 16'h0002, smac, ip), 1'b0);
        rx_beat(reply_data(16'h0806, 16'h0002, smac, ip), 1'b1);
        check("distract_ignored", bus.resp_valid, 1'b0);
        repeat (TO - 1 - 4) tick();
        rx_beat(reply_data(16'h0806, 16'h0002, smac, ip), 1'b1);
        check("edge_match_resp", {bus.resp_valid, bus.resp_fail}, 2'b10);
        check("edge_match_mac", bus.resp_mac, smac);
        check("edge_no_retx", txq.size(), 2);
        ack_resp();

        // Reset while the tail beat is stalled.
        txq.delete();
        issue_req($urandom);
        tick();
        check("rst_mid_in_tail", {bus.m_axis_tvalid, bus.m_axis_tlast}, 2'b11);
        bus.m_axis_tready = 1'b0;
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        bus.m_axis_tready = 1'b1;
        check("rst_mid_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_mid_req_ready", bus.req_ready, 1'b1);
        check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.resp_valid || bus.m_axis_tvalid) seen = 1'b1;
        end
        check("rst_mid_quiet", seen, 1'b0);
        check("rst_mid_beats", txq.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
